// File: rtl/sam_pkg.sv
// Shared SAM video-mode encodings and the per-mode line repeat table.
package sam_pkg;

  localparam logic [2:0] MODE_ALPHA = 3'b000;
  localparam logic [2:0] MODE_G1C   = 3'b001;
  localparam logic [2:0] MODE_G1R   = 3'b010;
  localparam logic [2:0] MODE_G2C   = 3'b011;
  localparam logic [2:0] MODE_G2R   = 3'b100;
  localparam logic [2:0] MODE_G3C   = 3'b101;
  localparam logic [2:0] MODE_G3R   = 3'b110;
  localparam logic [2:0] MODE_DMA   = 3'b111;

  function automatic logic [3:0] repeat_of(input logic [2:0] mode,
                                           input logic [3:0] text_repeat);
    logic [3:0] r;
    case (mode)
      MODE_ALPHA:         r = text_repeat;
      MODE_G1C, MODE_G1R: r = 4'd3;
      MODE_G2C, MODE_G2R: r = 4'd2;
      default:            r = 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sam_line_repeat.sv
// Line-within-row counter: decides at each HS event whether to rewind to the
// row base or commit the current address as the next row base.
module sam_line_repeat (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hs_ev,
  input  logic       fs_ev,
  input  logic [3:0] r,
  output logic       commit,
  output logic       rewind
);

  logic [3:0] line_cnt;
  logic [3:0] r_last;

  assign r_last = r - 4'd1;

  // Commit on >= so a mid-row switch to a smaller repeat count takes effect at once.
  always_comb begin
    commit = 1'b0;
    rewind = 1'b0;
    if (hs_ev && !fs_ev) begin
      if (line_cnt >= r_last) begin
        commit = 1'b1;
      end else begin
        rewind = 1'b1;
      end
    end else begin
      commit = 1'b0;
      rewind = 1'b0;
    end
  end

  // Line counter, cleared at frame start and at each row commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= 4'd0;
    end else if (fs_ev || commit) begin
      line_cnt <= 4'd0;
    end else if (rewind && (line_cnt != 4'd15)) begin
      line_cnt <= line_cnt + 4'd1;
    end else begin
      line_cnt <= line_cnt;
    end
  end

endmodule

// File: rtl/sam_video_counter.sv
// SAM video address generator: edge-detects the VDG strobes and steps the
// video fetch address, repeating each row's lines per the current mode.
module sam_video_counter
  import sam_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TEXT_REPEAT = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mode,
  input  logic [6:0]        disp_offset,
  input  logic              da0,
  input  logic              hs_n,
  input  logic              fs_n,
  output logic [ADDR_W-1:0] vaddr,
  output logic              row_adv
);

  logic              da0_q;
  logic              hs_q;
  logic              fs_q;
  logic              fs_ev;
  logic              hs_ev;
  logic              da_ev;
  logic              commit;
  logic              rewind;
  logic [3:0]        r;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] frame_base;

  // FS outranks HS, which outranks DA0; lower events in the same cycle are dropped.
  assign fs_ev      = fs_q & ~fs_n;
  assign hs_ev      = hs_q & ~hs_n & ~fs_ev;
  assign da_ev      = da0_q & ~da0 & ~hs_ev & ~fs_ev;
  assign r          = repeat_of(mode, 4'(TEXT_REPEAT));
  assign frame_base = ADDR_W'({disp_offset, 9'b0});

  sam_line_repeat u_line_repeat (
    .clk     (clk),
    .reset_n (reset_n),
    .hs_ev   (hs_ev),
    .fs_ev   (fs_ev),
    .r       (r),
    .commit  (commit),
    .rewind  (rewind)
  );

  // Strobe history resets to idle levels so no edge is seen on reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      da0_q <= 1'b0;
      hs_q  <= 1'b1;
      fs_q  <= 1'b1;
    end else begin
      da0_q <= da0;
      hs_q  <= hs_n;
      fs_q  <= fs_n;
    end
  end

  // Row base, fetch address and row-advance pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_base <= '0;
      vaddr    <= '0;
      row_adv  <= 1'b0;
    end else if (fs_ev) begin
      row_base <= frame_base;
      vaddr    <= frame_base;
      row_adv  <= 1'b0;
    end else if (commit) begin
      row_base <= vaddr;
      row_adv  <= 1'b1;
    end else if (rewind) begin
      vaddr    <= row_base;
      row_adv  <= 1'b0;
    end else if (da_ev) begin
      vaddr    <= vaddr + ADDR_W'(1);
      row_adv  <= 1'b0;
    end else begin
      row_adv  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sam_video_counter.sv
// Directed self-checking bench for sam_video_counter.
module tb_sam_video_counter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  mode;
  logic [6:0]  disp_offset;
  logic        da0;
  logic        hs_n;
  logic        fs_n;
  logic [15:0] vaddr;
  logic        row_adv;

  int total = 0;
  int bad   = 0;
  logic adv_hi;
  logic adv_after;

  sam_video_counter #(.ADDR_W(16), .TEXT_REPEAT(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .disp_offset (disp_offset),
    .da0         (da0),
    .hs_n        (hs_n),
    .fs_n        (fs_n),
    .vaddr       (vaddr),
    .row_adv     (row_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic da0_falls(input int n);
    for (int i = 0; i < n; i++) begin
      da0 = 1'b1; step();
      da0 = 1'b0; step();
    end
  endtask

  // HS fall; captures row_adv on the pulse cycle and the cycle after.
  task automatic hs_fall();
    hs_n = 1'b0; step();
    adv_hi = row_adv;
    hs_n = 1'b1; step();
    adv_after = row_adv;
  endtask

  task automatic fs_fall();
    fs_n = 1'b0; step();
    fs_n = 1'b1; step();
  endtask

  initial begin
    reset_n = 1'b0; mode = 3'b000; disp_offset = 7'h00;
    da0 = 1'b0; hs_n = 1'b1; fs_n = 1'b1;
    step(); step();
    chk("reset_vaddr", vaddr, 16'h0000);
    chk("reset_row_adv", {15'd0, row_adv}, 16'h0000);
    reset_n = 1'b1; step();

    // 1: build 0x1234 mid-line, then reset
    disp_offset = 7'h09; fs_fall();
    da0_falls(52);
    chk("pre_reset_vaddr", vaddr, 16'h1234);
    reset_n = 1'b0; step();
    chk("midline_reset_vaddr", vaddr, 16'h0000);
    chk("midline_reset_adv", {15'd0, row_adv}, 16'h0000);
    reset_n = 1'b1; step(); step(); step();
    chk("no_edge_after_release", vaddr, 16'h0000);

    // 2: frame start loads base
    disp_offset = 7'h02;
    fs_n = 1'b0; step();
    chk("fs_load_vaddr", vaddr, 16'h0400);
    chk("fs_no_adv", {15'd0, row_adv}, 16'h0000);
    fs_n = 1'b1; step();

    // 3: mode 110, one line per row
    mode = 3'b110;
    da0_falls(32);
    chk("m110_32_bytes", vaddr, 16'h0420);
    hs_fall();
    chk("m110_hs_vaddr", vaddr, 16'h0420);
    chk("m110_adv_pulse", {15'd0, adv_hi}, 16'h0001);
    chk("m110_adv_single", {15'd0, adv_after}, 16'h0000);

    // 4: text mode, 12 lines per row
    mode = 3'b000; fs_fall();
    for (int l = 0; l < 11; l++) begin
      da0_falls(32);
      hs_fall();
      chk($sformatf("m000_rewind_%0d", l), vaddr, 16'h0400);
      chk($sformatf("m000_no_adv_%0d", l), {15'd0, adv_hi}, 16'h0000);
    end
    da0_falls(32);
    hs_fall();
    chk("m000_hs12_vaddr", vaddr, 16'h0420);
    chk("m000_hs12_adv", {15'd0, adv_hi}, 16'h0001);

    // 5: mode 001, three lines per row, 16 bytes per line
    mode = 3'b001; fs_fall();
    da0_falls(16); hs_fall();
    chk("m001_hs1", vaddr, 16'h0400);
    da0_falls(16); hs_fall();
    chk("m001_hs2", vaddr, 16'h0400);
    chk("m001_hs2_no_adv", {15'd0, adv_hi}, 16'h0000);
    da0_falls(16); hs_fall();
    chk("m001_hs3", vaddr, 16'h0410);
    chk("m001_hs3_adv", {15'd0, adv_hi}, 16'h0001);

    // 5b: line_cnt=2 in text mode, switch to 110 -> next HS commits
    mode = 3'b000; fs_fall();
    da0_falls(16); hs_fall();
    da0_falls(16); hs_fall();
    chk("switch_pre_rewind", vaddr, 16'h0400);
    mode = 3'b110;
    da0_falls(16); hs_fall();
    chk("switch_commit_vaddr", vaddr, 16'h0410);
    chk("switch_commit_adv", {15'd0, adv_hi}, 16'h0001);

    // HS outranks a simultaneous DA0; offset change waits for FS
    mode = 3'b000; fs_fall();
    da0_falls(5);
    chk("five_bytes", vaddr, 16'h0405);
    disp_offset = 7'h10;
    da0 = 1'b1; step();
    da0 = 1'b0; hs_n = 1'b0; step();
    chk("hs_beats_da0", vaddr, 16'h0400);
    hs_n = 1'b1; step();

    // 6: FS, HS, DA0 together with offset 7F
    disp_offset = 7'h7F;
    da0 = 1'b1; step();
    da0 = 1'b0; hs_n = 1'b0; fs_n = 1'b0; step();
    chk("fs_priority_vaddr", vaddr, 16'hFE00);
    chk("fs_priority_no_adv", {15'd0, row_adv}, 16'h0000);
    hs_n = 1'b1; fs_n = 1'b1; step();
    chk("fs_priority_hold", vaddr, 16'hFE00);
    da0_falls(511);
    chk("top_of_space", vaddr, 16'hFFFF);
    da0_falls(1);
    chk("wrap_to_zero", vaddr, 16'h0000);
    chk("wrap_no_adv", {15'd0, row_adv}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
